rename_unit: RTL
================

RENAME_UNIT -- requirements
Module: rename_unit

Interface
REQ-001 Parameter NUM_ARCH, default 32: architectural registers; x0 is hard-wired to physical register 0.
REQ-002 Parameter NUM_PHYS, default 64: physical registers; the free list depth is NUM_PHYS-NUM_ARCH (32).
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  a decoded instruction is presented.
REQ-006 rs1, rs2  input  5 each  architectural source registers.
REQ-007 rd  input  5  architectural destination register.
REQ-008 rd_write  input  1  the instruction writes rd (0 for store and branch).
REQ-009 free_valid_0, free_valid_1  input  1 each  ROB retire slots release a physical register.
REQ-010 free_reg_0, free_reg_1  input  6 each  physical register released (the retired instruction's old_dr).
REQ-011 out_valid  output  1  the renamed instruction is valid; feeds ROB and issue.
REQ-012 ps1, ps2  output  6 each  physical sources.
REQ-013 pd  output  6  new physical destination; drives ROB dr.
REQ-014 old_pd  output  6  previous mapping of rd; drives ROB old_dr.
REQ-015 stall  output  1  combinational; rename cannot accept this cycle.
REQ-016 free_count  output  6  number of entries in the free list, 0..32.
REQ-017 overflow_err  output  1  sticky; set when a push is dropped because the free list is full.

Function
REQ-018 State: RAT of 32x6 bits, free-list circular FIFO of 32x6 bits, 5-bit head and tail pointers, and a 6-bit count.
REQ-019 Accept rule: an instruction is accepted when in_valid=1 and stall=0.
REQ-020 Outputs are registered, with a latency of 1 cycle from acceptance.
REQ-021 If in_valid=0 or stall=1, out_valid is 0 on the next cycle and the other outputs hold their values.
REQ-022 Allocation is needed when the instruction is accepted, rd_write=1 and rd!=0.
REQ-023 On allocation: pop the entry at head into pd, register RAT[rd] as old_pd, set RAT[rd]=pd, and advance head by 1 modulo 32.
REQ-024 When no allocation is needed: pd=0, old_pd=0, and the RAT and head are unchanged.
REQ-025 Sources: ps1=RAT[rs1] and ps2=RAT[rs2], read before this cycle's RAT update, so rs1==rd yields the old mapping.
REQ-026 rs==0 always yields 0.
REQ-027 Frees: each free_valid_n=1 with free_reg_n!=0 pushes free_reg_n at tail, then advances tail.
REQ-028 Slot 0 is pushed before slot 1.
REQ-029 free_reg_n==0 is ignored.
REQ-030 Count: count_next = count + pushes - pops, where pops is at most 1 and pushes is at most 2.
REQ-031 Pushes and a pop in the same cycle are both performed.
REQ-032 stall = in_valid & rd_write & (rd!=0) & (count==0), subject to REQ-040.
REQ-033 Full: a push that would exceed 32 entries is dropped and sets overflow_err.
REQ-034 When two frees arrive at count=31, slot 0 is kept and slot 1 is dropped, unless a pop occurs in the same cycle.
REQ-035 Head, tail and count wrap modulo 32, with no off-by-one at index 31->0.

Reset
REQ-036 While rst=1 (asynchronous): RAT[i]=i, free-list entry k holds 32+k, head=0, tail=0, count=32.
REQ-037 While rst=1, all outputs are 0 except free_count, which is 32.
REQ-038 Reset mid-operation discards all in-flight allocations, and the state machine resumes from the REQ-036 state on the first edge after rst falls.
REQ-039 overflow_err is cleared only by rst.

Configuration
REQ-040 Macro RENAME_FREE_BYPASS_EN defined: when count==0 and a valid nonzero free arrives in the same cycle, the lowest-slot free is forwarded directly to pd.
REQ-041 In the bypass case, that free is not pushed, stall stays 0, and count is unchanged by it.
REQ-042 Macro RENAME_FREE_BYPASS_EN undefined: stall follows REQ-032 regardless of same-cycle frees, which are pushed normally.

Verification
REQ-043 After reset, rename rd=5, rs1=5, rs2=0 -> next cycle out_valid=1, ps1=5, ps2=0, pd=32, old_pd=5, free_count=31.
REQ-044 32 back-to-back renames of rd=1 -> pd=32..63 in order with old_pd chaining 1,32,...,62; the 33rd rename stalls (stall=1) with count=0.
REQ-045 With count=0, free_valid_0=1 and free_reg_0=40 while rd=3 is presented -> bypass defined: pd=40 with no stall; bypass undefined: stall=1 that cycle, and the next cycle pd=40.
REQ-046 Drive rd_write=0 or rd=0 -> pd=0, old_pd=0, free_count unchanged, RAT unchanged.
REQ-047 At full count=32, drive free_valid_0=1 with free_reg_0=33 -> free_count stays 32 and overflow_err=1 until rst.
REQ-048 Assert rst asynchronously between clock edges mid-stream -> outputs clear immediately, and the next rename yields pd=32.

Source files
------------

// File: rtl/rename_if.sv
// rename_if: decode-to-rename request, ROB retire frees, and renamed-instruction result bundle.
//   Request : in_valid, rs1, rs2, rd, rd_write
//   Frees   : free_valid_0/1, free_reg_0/1 (released physical registers, slot 0 first)
//   Result  : out_valid, ps1, ps2, pd, old_pd (registered), stall (combinational),
//             free_count, overflow_err (sticky)
//   master drives requests and frees; slave is the rename unit.
interface rename_if #(
    parameter int AW = 5,
    parameter int PW = 6,
    parameter int CW = 6
);
    logic          in_valid;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [AW-1:0] rd;
    logic          rd_write;
    logic          free_valid_0;
    logic          free_valid_1;
    logic [PW-1:0] free_reg_0;
    logic [PW-1:0] free_reg_1;
    logic          out_valid;
    logic [PW-1:0] ps1;
    logic [PW-1:0] ps2;
    logic [PW-1:0] pd;
    logic [PW-1:0] old_pd;
    logic          stall;
    logic [CW-1:0] free_count;
    logic          overflow_err;

    modport master (
        output in_valid, rs1, rs2, rd, rd_write,
        output free_valid_0, free_valid_1, free_reg_0, free_reg_1,
        input  out_valid, ps1, ps2, pd, old_pd, stall, free_count, overflow_err
    );

    modport slave (
        input  in_valid, rs1, rs2, rd, rd_write,
        input  free_valid_0, free_valid_1, free_reg_0, free_reg_1,
        output out_valid, ps1, ps2, pd, old_pd, stall, free_count, overflow_err
    );
endinterface

// File: rtl/rename_unit.sv
// rename_unit: register alias table plus circular free list mapping architectural to physical registers.
//   clk, rst : clock and asynchronous active-high reset
//   io       : rename_if.slave (request, retire frees, renamed result, stall, free_count, overflow_err)
//   Optional : define RENAME_FREE_BYPASS_EN to forward a same-cycle free straight to pd
//              when the free list is empty instead of stalling.
module rename_unit #(
    parameter int NUM_ARCH = 32,
    parameter int NUM_PHYS = 64
) (
    input  logic     clk,
    input  logic     rst,
    rename_if.slave  io
);
    localparam int PW = $clog2(NUM_PHYS);
    localparam int FD = NUM_PHYS - NUM_ARCH;
    localparam int HW = $clog2(FD);
    localparam int CW = HW + 1;

    logic [PW-1:0] rat [NUM_ARCH];
    logic [PW-1:0] fl  [FD];
    logic [HW-1:0] head, tail;
    logic [CW-1:0] count;
    logic          out_valid, overflow_err;
    logic [PW-1:0] ps1, ps2, pd, old_pd;

    logic          v0, v1, empty, alloc_req, byp_avail, stall, accept, alloc, byp, pop;
    logic          push0, push1, ok0, ok1, drop;
    logic [PW-1:0] new_pd;
    logic [CW:0]   room;

    always_comb begin
        v0        = io.free_valid_0 & (io.free_reg_0 != '0);
        v1        = io.free_valid_1 & (io.free_reg_1 != '0);
        empty     = count == '0;
        alloc_req = io.in_valid & io.rd_write & (io.rd != '0);
`ifdef RENAME_FREE_BYPASS_EN
        byp_avail = empty & (v0 | v1);
`else
        byp_avail = 1'b0;
`endif
        stall     = alloc_req & empty & ~byp_avail;
        accept    = io.in_valid & ~stall;
        alloc     = accept & alloc_req;
        byp       = alloc & byp_avail;
        pop       = alloc & ~byp;
        new_pd    = byp ? (v0 ? io.free_reg_0 : io.free_reg_1) : fl[head];
        // the forwarded free (lowest valid slot) is consumed and never pushed
        push0     = v0 & ~byp;
        push1     = v1 & ~(byp & ~v0);
        // a same-cycle pop frees a slot, so it counts toward room for the pushes
        room      = (CW+1)'(FD) - (CW+1)'(count) + (CW+1)'(pop);
        ok0       = push0 & (room != '0);
        ok1       = push1 & (room > (CW+1)'(ok0));
        drop      = (push0 & ~ok0) | (push1 & ~ok1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ARCH; i++) rat[i] <= PW'(i);
            for (int k = 0; k < FD; k++) fl[k] <= PW'(NUM_ARCH + k);
            head         <= '0;
            tail         <= '0;
            count        <= CW'(FD);
            out_valid    <= 1'b0;
            ps1          <= '0;
            ps2          <= '0;
            pd           <= '0;
            old_pd       <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (alloc) rat[io.rd] <= new_pd;
            if (pop) head <= head + HW'(1);
            if (ok0) fl[tail] <= io.free_reg_0;
            if (ok1) fl[tail + HW'(ok0)] <= io.free_reg_1;
            tail  <= tail + HW'(ok0) + HW'(ok1);
            count <= count + CW'(ok0) + CW'(ok1) - CW'(pop);
            if (drop) overflow_err <= 1'b1;
            out_valid <= accept;
            if (accept) begin
                // RAT read here sees the pre-update mapping, so rs==rd gets the old register
                ps1    <= rat[io.rs1];
                ps2    <= rat[io.rs2];
                pd     <= alloc ? new_pd : '0;
                old_pd <= alloc ? rat[io.rd] : '0;
            end
        end
    end

    assign io.out_valid    = out_valid;
    assign io.ps1          = ps1;
    assign io.ps2          = ps2;
    assign io.pd           = pd;
    assign io.old_pd       = old_pd;
    assign io.stall        = stall;
    assign io.free_count   = count;
    assign io.overflow_err = overflow_err;
endmodule
